// File: rtl/serial_add16_pkg.sv
// Shared constants and FSM encoding for the nibble-serial 16-bit adder.
package serial_add16_pkg;

  localparam int unsigned NumNibbles = 4;
  localparam int unsigned NibbleW    = 4;
  localparam int unsigned DataW      = NumNibbles * NibbleW;
  localparam int unsigned IdxW       = 2;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumNibbles - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/gg.sv
// 4-bit ripple-carry adder stage.
module gg (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       Cin,
  output logic [3:0] s,
  output logic       Co
);

  // Ripple the carry bit by bit through four full adders.
  always_comb begin
    logic c;
    c = Cin;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    Co = c;
  end

endmodule

// File: rtl/serial_add16.sv
// Nibble-serial 16-bit adder: one 4-bit stage reused over four ADD cycles,
// valid/ready handshake on both sides, all outputs registered.
module serial_add16
  import serial_add16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DataW-1:0] a,
  input  logic [DataW-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DataW-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [DataW-1:0]  a_q;
  logic [DataW-1:0]  b_q;
  logic              carry_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [DataW-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;

  logic [NibbleW-1:0] a_nib;
  logic [NibbleW-1:0] b_nib;
  logic [NibbleW-1:0] nib_s;
  logic               nib_co;
  logic               ovf_final;

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    a_nib = a_q[NibbleW*idx_q +: NibbleW];
    b_nib = b_q[NibbleW*idx_q +: NibbleW];
  end

  gg u_stage (
    .a   (a_nib),
    .b   (b_nib),
    .Cin (carry_q),
    .s   (nib_s),
    .Co  (nib_co)
  );

  // Signed overflow judged on the top nibble's fresh result bit.
  assign ovf_final = (a_q[DataW-1] == b_q[DataW-1]) && (nib_s[NibbleW-1] != a_q[DataW-1]);

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= cin;
            idx_q      <= '0;
            state_q    <= StAdd;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StAdd: begin
          sum_q[NibbleW*idx_q +: NibbleW] <= nib_s;
          carry_q <= nib_co;
          idx_q   <= idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            cout_q      <= nib_co;
            ovf_q       <= ovf_final;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean idle.
          state_q     <= StIdle;
          idx_q       <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add16.sv
// Self-checking bench for serial_add16: directed table, handshake corner cases,
// and randomized back-to-back traffic against an arithmetic reference.
module tb_serial_add16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  serial_add16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
  } res_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow as a range check.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic ci);
    res_t r;
    int unsigned u;
    int          sg;
    u   = int'(x) + int'(y) + int'(ci);
    sg  = int'($signed(x)) + int'($signed(y)) + int'(ci);
    r.s = u[15:0];
    r.c = u[16];
    r.v = (sg > 32767) || (sg < -32768);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair with out_ready high and verify latency and result.
  task automatic run_op(input string name, input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic [15:0] es, input logic ec,
                        input logic ev);
    int n;
    a = x; b = y; cin = ci; in_valid = 1'b1; out_ready = 1'b1;
    check({name, ".ready_before"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check({name, ".busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check({name, ".latency"}, 32'(n), 32'd4);
    check({name, ".sum"}, 32'(sum), 32'(es));
    check({name, ".cout"}, 32'(cout), 32'(ec));
    check({name, ".ovf"}, 32'(ovf), 32'(ev));
    tick();
    check({name, ".handoff"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    vec_t vecs[7];
    res_t r;
    int   cyc, last_acc, n_acc, n_chk;
    res_t expq[$];
    logic ok;

    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.sum", 32'(sum), 32'd0);
    check("rst.cout_ovf", {30'd0, cout, ovf}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
    end

    // Back-pressure: result held while out_ready low, new requests ignored.
    a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("bp.valid_at_4", 32'(out_valid), 32'd1);
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0; in_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && sum === 16'h5556 && busy === 1'b1))
        ok = 1'b0;
      tick();
    end
    check("bp.held_10", 32'(ok), 32'd1);
    check("bp.still_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp.handoff", {30'd0, out_valid, in_ready}, 32'd1);
    check("bp.sum_retained", 32'(sum), 32'h5556);

    // Reset during the second ADD cycle aborts without a result.
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst.in_ready", 32'(in_ready), 32'd1);
    check("mid_rst.out_valid", 32'(out_valid), 32'd0);
    check("mid_rst.busy", 32'(busy), 32'd0);
    check("mid_rst.sum", 32'(sum), 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0) ok = 1'b0;
      tick();
    end
    check("mid_rst.no_result", 32'(ok), 32'd1);
    run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Random back-to-back traffic: accepts every 6 cycles, results in order.
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; last_acc = -1; n_acc = 0; n_chk = 0;
    while (n_chk < 1000 && cyc < 8000) begin
      logic acc, outv;
      acc  = in_valid && in_ready;
      outv = out_valid;
      if (outv) begin
        if (expq.size() == 0) begin
          check("rand.spurious_result", 32'd1, 32'd0);
        end else begin
          r = expq.pop_front();
          check("rand.sum", 32'(sum), 32'(r.s));
          check("rand.cout", 32'(cout), 32'(r.c));
          check("rand.ovf", 32'(ovf), 32'(r.v));
        end
        n_chk++;
      end
      tick();
      cyc++;
      if (acc) begin
        expq.push_back(model(a, b, cin));
        if (last_acc >= 0) check("rand.spacing", 32'(cyc - last_acc), 32'd6);
        last_acc = cyc;
        n_acc++;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        if (n_acc == 1000) in_valid = 1'b0;
      end
    end
    check("rand.completed", 32'(n_chk), 32'd1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
